// File: rtl/rrp_pkg.sv
// Shared definitions for the round-robin adder scheduler: digit/operand
// width derivation, result FIFO sizing and the requester ID type.
package rrp_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  // Requester identity carried alongside every result.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  // Bits per signed digit: magnitude bits plus a sign bit.
  function automatic int calc_d(input int radix);
    return $clog2(radix) + 1;
  endfunction

  // Packed operand width for `width` digits.
  function automatic int calc_n(input int radix, input int width);
    return calc_d(radix) * width;
  endfunction

endpackage

// File: rtl/rRp_add_clocked.sv
// Two-stage clocked signed-digit (online-style) adder. Digits are two's
// complement, digit set {-(RADIX-1)..RADIX-1}. Stage 1 registers the
// operands, stage 2 registers the carry-free sum, so a pair presented in
// cycle c appears on s_out during cycle c+2. Data registers carry no reset.
module rRp_add_clocked #(
  parameter int RADIX = 4,
  parameter int WIDTH = 15,
  localparam int D = $clog2(RADIX) + 1,
  localparam int N = D * WIDTH
) (
  input  logic         clock,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic [N+D-1:0] s_out
);

  // Two guard bits cover the digit-pair sum range of +/-2(RADIX-1).
  localparam int E = D + 2;
  localparam logic signed [E-1:0] TH  = E'(RADIX - 1);
  localparam logic signed [E-1:0] RV  = E'(RADIX);
  localparam logic signed [E-1:0] ONE = E'(1);

  logic [N-1:0]   x_q, y_q;
  logic [N+D-1:0] s_d, s_q;

  // Operand and sum pipeline registers.
  always_ff @(posedge clock) begin
    x_q <= x_in;
    y_q <= y_in;
    s_q <= s_d;
  end

  // Per digit: p = x+y split into transfer t (to the next digit) and
  // interim w, then s = w + incoming t. Thresholds at +/-(RADIX-1) keep
  // every output digit inside the digit set, so no carry ripples.
  always_comb begin
    logic signed [E-1:0] xd, yd, p, w, t_in, t_out;
    s_d   = '0;
    xd    = '0;
    yd    = '0;
    p     = '0;
    w     = '0;
    t_in  = '0;
    t_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      xd = E'($signed(x_q[i*D +: D]));
      yd = E'($signed(y_q[i*D +: D]));
      p  = xd + yd;
      if (p >= TH) begin
        t_out = ONE;
        w     = p - RV;
      end else if (p <= -TH) begin
        t_out = -ONE;
        w     = p + RV;
      end else begin
        t_out = '0;
        w     = p;
      end
      s_d[i*D +: D] = D'(w + t_in);
      t_in = t_out;
    end
    s_d[N +: D] = D'(t_in);
  end

  assign s_out = s_q;

endmodule

// File: rtl/rrp_result_fifo.sv
// Four-entry result FIFO with a combinational head. Push and pop in the
// same cycle leave the count unchanged; a pop on an empty FIFO is ignored.
module rrp_result_fifo
  import rrp_pkg::*;
#(
  parameter type entry_t = logic [7:0]
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until counted in.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Overflow guards; the scheduler's credit scheme keeps these unreachable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(FIFO_DEPTH));
      assert (!(push && (count_q == CNT_W'(FIFO_DEPTH)) && !do_pop));
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rrp_add_sched.sv
// Round-robin scheduler sharing one rRp_add_clocked adder between two
// requesters. Accepted pairs are tagged through the adder's two stages and
// the tagged sums are buffered in a 4-entry result FIFO.
//
// Handshakes: a transfer happens on a port in any cycle where valid and
// ready are both high. reqK_ready is combinational from the two valids and
// the credit state only (never from res_ready). res_valid/res_s/res_id are
// stable while res_valid is high and res_ready low; the head leaves on
// res_valid && res_ready.
module rrp_add_sched
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 15,
  localparam int D = calc_d(RADIX),
  localparam int N = calc_n(RADIX, WIDTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_x,
  input  logic [N-1:0]   req0_y,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_x,
  input  logic [N-1:0]   req1_y,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N+D-1:0] res_s,
  output logic           res_id,
  output logic           busy
);

  typedef struct packed {
    port_id_t       id;
    logic [N+D-1:0] s;
  } res_entry_t;

  logic             p1_q, p1_d, p2_q, p2_d;
  port_id_t         id1_q, id1_d, id2_q, id2_d;
  port_id_t         last_q, last_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] occ;
  logic             issue_ok;
  logic             grant;
  port_id_t         grant_id;
  logic [N-1:0]     add_x, add_y;
  logic [N+D-1:0]   add_s;
  res_entry_t       push_entry, head_entry;
  logic             fifo_nonempty;
  logic             pop;

  // Credit check, round-robin arbitration, readys and adder operand mux.
  // Occupancy counts buffered plus in-flight results; a same-cycle pop is
  // deliberately not credited so ready never depends on res_ready.
  always_comb begin
    occ      = fifo_count + CNT_W'(p1_q) + CNT_W'(p2_q);
    issue_ok = !reset && (occ < CNT_W'(FIFO_DEPTH));
    grant_id = PORT0;
    if (req0_valid && req1_valid) begin
      grant_id = (last_q == PORT0) ? PORT1 : PORT0;
    end else if (req1_valid) begin
      grant_id = PORT1;
    end
    grant      = issue_ok && (req0_valid || req1_valid);
    req0_ready = grant && (grant_id == PORT0);
    req1_ready = grant && (grant_id == PORT1);
    add_x      = '0;
    add_y      = '0;
    if (grant) begin
      add_x = (grant_id == PORT1) ? req1_x : req0_x;
      add_y = (grant_id == PORT1) ? req1_y : req0_y;
    end
  end

  // Tag pipeline next-state: mirrors the adder's two register stages.
  always_comb begin
    p1_d   = grant;
    id1_d  = grant_id;
    p2_d   = p1_q;
    id2_d  = id1_q;
    last_d = grant ? grant_id : last_q;
  end

  // Valid bits and arbitration pointer; reset discards in-flight work and
  // points `last` at port 1 so port 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_q   <= 1'b0;
      p2_q   <= 1'b0;
      last_q <= PORT1;
    end else begin
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      last_q <= last_d;
    end
  end

  // ID tags follow the valid bits; only meaningful when the bit is set.
  always_ff @(posedge clock) begin
    id1_q <= id1_d;
    id2_q <= id2_d;
  end

  rRp_add_clocked #(
    .RADIX (RADIX),
    .WIDTH (WIDTH)
  ) u_add (
    .clock (clock),
    .x_in  (add_x),
    .y_in  (add_y),
    .s_out (add_s)
  );

  assign push_entry    = '{id: id2_q, s: add_s};
  assign fifo_nonempty = (fifo_count != '0);
  assign res_valid     = !reset && fifo_nonempty;
  assign pop           = res_valid && res_ready;

  rrp_result_fifo #(
    .entry_t (res_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (p2_q),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count)
  );

  assign res_s  = head_entry.s;
  assign res_id = head_entry.id;
  assign busy   = !reset && (p1_q || p2_q || fifo_nonempty);

endmodule

// File: tb/tb_rrp_add_sched.sv
// Testbench for rrp_add_sched with RADIX=4, WIDTH=4 (3-bit digits).
module tb_rrp_add_sched;

  localparam int RADIX = 4;
  localparam int WIDTH = 4;
  localparam int D     = 3;
  localparam int N     = D * WIDTH;
  localparam int S     = N + D;
  localparam int SBW   = 33;

  // ---------------- clock / reset / DUT ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         res_valid, res_ready, res_id, busy;
  logic [S-1:0] res_s;

  always #5 clock = ~clock;

  rrp_add_sched #(.RADIX(RADIX), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_s      (res_s),
    .res_id     (res_id),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [SBW-1:0] exp_q[$];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Numeric value of a packed signed-digit vector (digit 0 in LSBs).
  function automatic int sd_value(input logic [S-1:0] v, input int nd);
    int acc;
    logic signed [D-1:0] dg;
    acc = 0;
    for (int i = nd - 1; i >= 0; i--) begin
      dg  = v[i*D +: D];
      acc = acc * RADIX + int'(dg);
    end
    return acc;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      v = int'($urandom_range(6, 0)) - 3;
      r[i*D +: D] = v[D-1:0];
    end
    return r;
  endfunction

  function automatic logic [SBW-1:0] exp_entry(input logic id, input logic [N-1:0] x,
                                               input logic [N-1:0] y);
    int val;
    val = sd_value({{D{1'b0}}, x}, WIDTH) + sd_value({{D{1'b0}}, y}, WIDTH);
    return {id, 32'(val)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [SBW-1:0] sb_e;
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      check("both_ready", 32'(req0_ready && req1_ready), 32'd0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_id", 32'(res_id), 32'(sb_e[32]));
          check("sb_value", 32'(sd_value(res_s, WIDTH + 1)), sb_e[31:0]);
        end
      end
      if (req0_valid && req0_ready) exp_q.push_back(exp_entry(1'b0, req0_x, req0_y));
      if (req1_valid && req1_ready) exp_q.push_back(exp_entry(1'b1, req1_x, req1_y));
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge.
  task automatic apply_reset(input int ncyc, input logic chk);
    reset = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clock);
      if (chk) begin
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    k = 0;
    @(negedge clock);
    while (busy && k < 40) begin
      @(negedge clock);
      k++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         port;
    logic [N-1:0] x;
    logic [N-1:0] y;
    int           exp_val;
    logic         chk_digits;
    logic [S-1:0] exp_s;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // all +1 = 12'h249, all +2 = 12'h492, all +3 = 12'h6DB, all -3 = 12'hB6D
    vecs[0] = '{1'b0, 12'h249, 12'h249,  170, 1'b1, 15'h0492}; // [0,2,2,2,2]
    vecs[1] = '{1'b1, 12'h6DB, 12'h6DB,  510, 1'b1, 15'h16DA}; // [1,3,3,3,2]
    vecs[2] = '{1'b0, 12'hB6D, 12'hB6D, -510, 1'b0, 15'h0000};
    vecs[3] = '{1'b1, 12'h000, 12'h000,    0, 1'b1, 15'h0000};
    vecs[4] = '{1'b0, 12'h6DB, 12'hB6D,    0, 1'b0, 15'h0000};
    vecs[5] = '{1'b1, 12'h492, 12'h249,  255, 1'b0, 15'h0000};

    reset      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    res_ready  = 1'b0;
    @(posedge clock); #1;
    apply_reset(2, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    check("post_rst_res_valid", 32'(res_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;

    // ---- table: single operations with exact latency ----
    for (int v = 0; v < 6; v++) begin
      res_ready = 1'b1;
      if (vecs[v].port) begin
        req1_valid = 1'b1; req1_x = vecs[v].x; req1_y = vecs[v].y;
      end else begin
        req0_valid = 1'b1; req0_x = vecs[v].x; req0_y = vecs[v].y;
      end
      @(negedge clock);
      check($sformatf("vec%0d_ready", v),
            32'(vecs[v].port ? req1_ready : req0_ready), 32'd1);
      @(posedge clock); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clock);
        check($sformatf("vec%0d_res_valid_c%0d", v, c), 32'(res_valid), 32'(c == 3));
        if (c == 3) begin
          check($sformatf("vec%0d_res_id", v), 32'(res_id), 32'(vecs[v].port));
          check($sformatf("vec%0d_value", v), 32'(sd_value(res_s, WIDTH + 1)),
                32'(vecs[v].exp_val));
          if (vecs[v].chk_digits)
            check($sformatf("vec%0d_digits", v), 32'(res_s), 32'(vecs[v].exp_s));
        end
        @(posedge clock); #1;
      end
      @(negedge clock);
      check($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
      @(posedge clock); #1;
    end

    // ---- contention from reset: grants 0,1,0,1,0,1, ids 3 cycles later ----
    apply_reset(1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      req0_valid = (i < 6); req1_valid = (i < 6);
      req0_x = rand_op(); req0_y = rand_op();
      req1_x = rand_op(); req1_y = rand_op();
      res_ready = 1'b1;
      @(negedge clock);
      if (i < 6) begin
        check($sformatf("cont_g0_c%0d", i), 32'(req0_ready), 32'((i % 2) == 0));
        check($sformatf("cont_g1_c%0d", i), 32'(req1_ready), 32'((i % 2) == 1));
      end
      if (i >= 3) begin
        check($sformatf("cont_res_valid_c%0d", i), 32'(res_valid), 32'd1);
        check($sformatf("cont_res_id_c%0d", i), 32'(res_id), 32'((i - 3) % 2));
      end
      @(posedge clock); #1;
    end
    drain("cont");

    // ---- backpressure: 4 accepts, stall, one pop frees one slot ----
    for (int i = 0; i < 15; i++) begin
      req0_valid = 1'b1;
      req0_x = rand_op(); req0_y = rand_op();
      res_ready = (i == 10);
      @(negedge clock);
      check($sformatf("bp_ready_c%0d", i), 32'(req0_ready), 32'((i < 4) || (i == 11)));
      @(posedge clock); #1;
    end
    drain("bp");

    // ---- reset one cycle after a transfer ----
    req0_valid = 1'b1; req0_x = vecs[0].x; req0_y = vecs[0].y;
    @(negedge clock);
    check("mid_xfer_ready", 32'(req0_ready), 32'd1);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    apply_reset(1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("mid_res_valid_c%0d", i), 32'(res_valid), 32'd0);
      check($sformatf("mid_busy_c%0d", i), 32'(busy), 32'd0);
      @(posedge clock); #1;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clock);
    check("mid_first_g0", 32'(req0_ready), 32'd1);
    check("mid_first_g1", 32'(req1_ready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("mid_second_g1", 32'(req1_ready), 32'd1);
    @(posedge clock); #1;
    drain("mid");

    // ---- random traffic ----
    for (int i = 0; i < 10000; i++) begin
      req0_valid = 1'($urandom_range(1, 0));
      req1_valid = 1'($urandom_range(1, 0));
      req0_x = rand_op(); req0_y = rand_op();
      req1_x = rand_op(); req1_y = rand_op();
      res_ready = ($urandom_range(3, 0) != 0);
      @(posedge clock); #1;
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
